// File: rtl/alu_muldiv_pkg.sv
// Shared opcode encodings, FSM states and operation kinds for the multiply/divide unit.
// Opcodes share the ALU opcode space; ALU ops live alongside these in the same numbering.
package alu_muldiv_pkg;

    localparam logic [5:0] OP_MULT  = 6'b010100;
    localparam logic [5:0] OP_MULTU = 6'b010101;
    localparam logic [5:0] OP_DIV   = 6'b010110;
    localparam logic [5:0] OP_DIVU  = 6'b010111;
    localparam logic [5:0] OP_MFHI  = 6'b011000;
    localparam logic [5:0] OP_MFLO  = 6'b011001;
    localparam logic [5:0] OP_MTHI  = 6'b011010;
    localparam logic [5:0] OP_MTLO  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    typedef enum logic [3:0] {
        K_NONE,
        K_MULT,
        K_MULTU,
        K_DIV,
        K_DIVU,
        K_MFHI,
        K_MFLO,
        K_MTHI,
        K_MTLO
    } kind_t;

    function automatic logic is_iterative(input kind_t k);
        return (k == K_MULT) || (k == K_MULTU) || (k == K_DIV) || (k == K_DIVU);
    endfunction

    function automatic logic is_divide(input kind_t k);
        return (k == K_DIV) || (k == K_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: one shift-add (multiply) or restoring shift-subtract (divide) step per enable.
// Accumulator low half starts as multiplier/dividend; after N steps it holds {HI,LO} or {rem,quot}.
module muldiv_iter #(
    parameter int N_BITS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_en,
    input  logic                  i_is_div,
    input  logic [N_BITS-1:0]     i_a,
    input  logic [N_BITS-1:0]     i_b,
    output logic [2*N_BITS-1:0]   o_acc
);

    logic [2*N_BITS-1:0] r_acc;
    logic [N_BITS-1:0]   r_b;

    logic [N_BITS:0]     w_sum;
    logic [2*N_BITS-1:0] w_mul_next;
    logic [N_BITS:0]     w_rem_sh;
    logic                w_ge;
    logic [N_BITS-1:0]   w_diff;
    logic [2*N_BITS-1:0] w_div_next;

    always_comb begin
        w_sum      = {1'b0, r_acc[2*N_BITS-1:N_BITS]} + {1'b0, r_b};
        w_mul_next = r_acc[0] ? {w_sum, r_acc[N_BITS-1:1]}
                              : {1'b0, r_acc[2*N_BITS-1:1]};

        // Shifted partial remainder needs one extra bit; a successful
        // subtraction always lands below the divisor, so N bits suffice after.
        w_rem_sh   = {r_acc[2*N_BITS-1:N_BITS], r_acc[N_BITS-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_b});
        w_diff     = w_rem_sh[N_BITS-1:0] - r_b;
        w_div_next = w_ge ? {w_diff, r_acc[N_BITS-2:0], 1'b1}
                          : {w_rem_sh[N_BITS-1:0], r_acc[N_BITS-2:0], 1'b0};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
        end else if (i_load) begin
            r_acc <= {{N_BITS{1'b0}}, i_a};
            r_b   <= i_b;
        end else if (i_en) begin
            r_acc <= i_is_div ? w_div_next : w_mul_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MFxx/MTxx access.
// Holds the FSM, step counter, sign fix-up and architectural HI/LO/result registers.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int N_BITS   = 32,
    parameter int N_OPCODE = 6
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [N_OPCODE-1:0] i_opcode,
    input  logic [N_BITS-1:0]   i_datoA,
    input  logic [N_BITS-1:0]   i_datoB,
    output logic                o_busy,
    output logic                o_done,
    output logic [N_BITS-1:0]   o_result,
    output logic [N_BITS-1:0]   o_hi,
    output logic [N_BITS-1:0]   o_lo,
    output logic                o_div_by_zero
);

    localparam int CW = $clog2(N_BITS + 1);

    state_t              r_state, w_next;
    kind_t               r_kind, w_kind;
    logic [CW-1:0]       r_cnt;
    logic                r_neg_q, r_neg_r, r_div0;
    logic [N_BITS-1:0]   r_a, r_hi, r_lo, r_result;
    logic                r_done, r_dbz;

    logic                w_accept, w_signed, w_div0;
    logic [N_BITS-1:0]   w_mag_a, w_mag_b;
    logic [2*N_BITS-1:0] w_acc, w_prod;
    logic [N_BITS-1:0]   w_quot, w_rem;

    always_comb begin
        w_kind = K_NONE;
        case (i_opcode)
            N_OPCODE'(OP_MULT):  w_kind = K_MULT;
            N_OPCODE'(OP_MULTU): w_kind = K_MULTU;
            N_OPCODE'(OP_DIV):   w_kind = K_DIV;
            N_OPCODE'(OP_DIVU):  w_kind = K_DIVU;
            N_OPCODE'(OP_MFHI):  w_kind = K_MFHI;
            N_OPCODE'(OP_MFLO):  w_kind = K_MFLO;
            N_OPCODE'(OP_MTHI):  w_kind = K_MTHI;
            N_OPCODE'(OP_MTLO):  w_kind = K_MTLO;
            default:             w_kind = K_NONE;
        endcase
    end

    assign w_accept = i_start && (r_state == ST_IDLE) && !r_done && (w_kind != K_NONE);
    assign w_signed = (w_kind == K_MULT) || (w_kind == K_DIV);
    assign w_div0   = is_divide(w_kind) && (i_datoB == '0);
    assign w_mag_a  = (w_signed && i_datoA[N_BITS-1]) ? -i_datoA : i_datoA;
    assign w_mag_b  = (w_signed && i_datoB[N_BITS-1]) ? -i_datoB : i_datoB;

    muldiv_iter #(.N_BITS(N_BITS)) u_iter (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_accept),
        .i_en     (r_state == ST_CALC),
        .i_is_div (is_divide(r_kind)),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .o_acc    (w_acc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (is_iterative(w_kind) && !w_div0) ? ST_CALC : ST_DONE;
            ST_CALC: if (r_cnt == CW'(1)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_prod = r_neg_q ? -w_acc : w_acc;
    assign w_quot = r_neg_q ? -w_acc[N_BITS-1:0] : w_acc[N_BITS-1:0];
    assign w_rem  = r_neg_r ? -w_acc[2*N_BITS-1:N_BITS] : w_acc[2*N_BITS-1:N_BITS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_kind   <= K_NONE;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_DONE);
            if (w_accept) begin
                r_kind  <= w_kind;
                r_a     <= i_datoA;
                r_div0  <= w_div0;
                r_neg_q <= w_signed && (i_datoA[N_BITS-1] ^ i_datoB[N_BITS-1]);
                r_neg_r <= (w_kind == K_DIV) && i_datoA[N_BITS-1];
                r_dbz   <= 1'b0;
                r_cnt   <= CW'(N_BITS);
            end else if (r_state == ST_CALC) begin
                r_cnt <= r_cnt - CW'(1);
            end
            // Architectural state only changes here, so CALC never exposes partial results.
            if (r_state == ST_DONE) begin
                r_dbz <= r_div0;
                case (r_kind)
                    K_MULT, K_MULTU: begin
                        r_hi <= w_prod[2*N_BITS-1:N_BITS];
                        r_lo <= w_prod[N_BITS-1:0];
                    end
                    K_DIV, K_DIVU: begin
                        if (r_div0) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                    end
                    K_MFHI:  r_result <= r_hi;
                    K_MFLO:  r_result <= r_lo;
                    K_MTHI:  r_hi <= r_a;
                    K_MTLO:  r_lo <= r_a;
                    default: ;
                endcase
            end
        end
    end

    assign o_busy        = (r_state != ST_IDLE) || r_done;
    assign o_done        = r_done;
    assign o_result      = r_result;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expected HI/LO/result/flags/latency,
// a monitor pops and compares on every o_done; reference uses plain 64-bit arithmetic.
module tb_alu_muldiv;

    localparam logic [5:0] OP_MULT  = 6'b010100;
    localparam logic [5:0] OP_MULTU = 6'b010101;
    localparam logic [5:0] OP_DIV   = 6'b010110;
    localparam logic [5:0] OP_DIVU  = 6'b010111;
    localparam logic [5:0] OP_MFHI  = 6'b011000;
    localparam logic [5:0] OP_MFLO  = 6'b011001;
    localparam logic [5:0] OP_MTHI  = 6'b011010;
    localparam logic [5:0] OP_MTLO  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [5:0]  i_opcode;
    logic [31:0] i_datoA, i_datoB;
    logic        o_busy, o_done, o_div_by_zero;
    logic [31:0] o_result, o_hi, o_lo;

    alu_muldiv #(.N_BITS(32), .N_OPCODE(6)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_opcode      (i_opcode),
        .i_datoA       (i_datoA),
        .i_datoB       (i_datoB),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_hi          (o_hi),
        .o_lo          (o_lo),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] hi, lo, res;
        logic        dbz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_vec = 0, n_cmp = 0, n_err = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: got o_done=1 with no outstanding op, expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("hi op=%b", e.op), 64'(o_hi), 64'(e.hi));
                chk($sformatf("lo op=%b", e.op), 64'(o_lo), 64'(e.lo));
                chk($sformatf("result op=%b", e.op), 64'(o_result), 64'(e.res));
                chk($sformatf("dbz op=%b", e.op), 64'(o_div_by_zero), 64'(e.dbz));
                chk($sformatf("latency op=%b", e.op), 64'(cyc - e.acc), 64'(e.lat));
                chk($sformatf("busy_at_done op=%b", e.op), 64'(o_busy), 64'd1);
            end
        end
    end

    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        bit          known;
        longint      p, r;
        logic [63:0] u;
        int          w;
        w = 0;
        @(negedge clk);
        while (o_busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (o_busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_wait: got o_busy=1 after 200 cycles, expected 0");
        end
        i_start  = 1'b1;
        i_opcode = op;
        i_datoA  = a;
        i_datoB  = b;
        known    = 1'b1;
        e.lat    = 1;
        e.dbz    = 1'b0;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                u = 64'(p);
                m_hi = u[63:32]; m_lo = u[31:0]; e.lat = 33;
            end
            OP_MULTU: begin
                u = {32'b0, a} * {32'b0, b};
                m_hi = u[63:32]; m_lo = u[31:0]; e.lat = 33;
            end
            OP_DIV: begin
                if (b == 0) begin
                    m_hi = a; m_lo = '1; e.dbz = 1'b1;
                end else begin
                    p = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = 32'(p); m_hi = 32'(r); e.lat = 33;
                end
            end
            OP_DIVU: begin
                if (b == 0) begin
                    m_hi = a; m_lo = '1; e.dbz = 1'b1;
                end else begin
                    m_lo = a / b; m_hi = a % b; e.lat = 33;
                end
            end
            OP_MFHI: m_res = m_hi;
            OP_MFLO: m_res = m_lo;
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: known = 1'b0;
        endcase
        if (known) begin
            e.op  = op;
            e.hi  = m_hi;
            e.lo  = m_lo;
            e.res = m_res;
            e.acc = cyc + 1;
            q.push_back(e);
        end
        n_vec++;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops [8];
        int         w;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
        rst_n    = 1'b0;
        i_start  = 1'b0;
        i_opcode = '0;
        i_datoA  = '0;
        i_datoB  = '0;
        #23;
        chk("reset_hi", 64'(o_hi), 64'd0);
        chk("reset_lo", 64'(o_lo), 64'd0);
        chk("reset_result", 64'(o_result), 64'd0);
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_done", 64'(o_done), 64'd0);
        chk("reset_dbz", 64'(o_div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        do_op(OP_DIVU,  32'd7, 32'd2);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        do_op(OP_DIVU,  32'd5, 32'd0);
        do_op(OP_MTHI,  32'h0000_1234, 32'd0);
        do_op(OP_MFHI,  32'd0, 32'd0);
        do_op(OP_MFLO,  32'd0, 32'd0);

        // Request while busy must be dropped; HI ends up as the product.
        do_op(OP_MULT, 32'd123456, 32'hFFFF_FF00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_mid_calc", 64'(o_busy), 64'd1);
        i_start  = 1'b1;
        i_opcode = OP_MTHI;
        i_datoA  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        do_op(OP_MFHI, 32'd0, 32'd0);

        // Unknown opcode: no completion and no busy.
        do_op(6'b111111, 32'h1, 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("unknown_busy", 64'(o_busy), 64'd0);
            chk("unknown_done", 64'(o_done), 64'd0);
        end

        // Reset mid-MULT discards the op and clears HI/LO at once.
        do_op(OP_MTLO, 32'h0000_0066, 32'd0);
        do_op(OP_MULT, 32'd1000, 32'd3000);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(o_busy), 64'd0);
        chk("rst_mid_done", 64'(o_done), 64'd0);
        chk("rst_mid_hi", 64'(o_hi), 64'd0);
        chk("rst_mid_lo", 64'(o_lo), 64'd0);
        chk("rst_mid_result", 64'(o_result), 64'd0);
        void'(q.pop_back());
        m_hi = '0; m_lo = '0; m_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        do_op(OP_MFLO, 32'd0, 32'd0);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0)
                do_op(6'b000000, rnd_operand(), rnd_operand());
            else
                do_op(ops[$urandom_range(0, 7)], rnd_operand(), rnd_operand());
        end

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d outstanding ops after timeout, expected 0", q.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
